uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, frame data bits; legal range 5..9.
REQ-002 Parameter PRESC_W, default 8, width of the bit-period input.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 data_in  input  DATA_WIDTH  parallel word to transmit, LSB sent first.
REQ-006 data_valid  input  1  word offered; transferred when data_valid and ready are both high in the same cycle.
REQ-007 ready  output  1  combinational; high when a word can be transferred this cycle.
REQ-008 parity_en  input  1  1 = append parity bit.
REQ-009 parity_odd  input  1  0 = even parity, 1 = odd parity.
REQ-010 stop2_en  input  1  1 = two stop bits, 0 = one.
REQ-011 bit_period  input  PRESC_W  clocks per serial bit; 0 is treated as 1.
REQ-012 break_req  input  1  line-break request; present only with UART_TX_BREAK_EN.
REQ-013 tx_out  output  1  registered serial line, idle high.
REQ-014 busy  output  1  registered; high in every state except IDLE.

Function
REQ-015 States: IDLE, START, DATA, PARITY, STOP1, STOP2, plus BREAK under UART_TX_BREAK_EN.
REQ-016 ready is high in IDLE, and in the last clock of the final stop bit; it is low otherwise.
REQ-017 On transfer, data_in, parity_en, parity_odd, stop2_en and bit_period (0->1) are latched. Input changes mid-frame do not affect the current frame.
REQ-018 If a transfer occurs in cycle N, tx_out = 0 (start bit) from cycle N+1.
REQ-019 Each bit holds tx_out for exactly the latched bit_period clocks, timed by a down-counter reloaded at every bit boundary.
REQ-020 Frame order: START(0), DATA bits 0..DATA_WIDTH-1, PARITY if enabled, STOP1(1), then STOP2(1) if stop2_en.
REQ-021 Parity bit = XOR of the latched data bits when even, and its inverse when odd.
REQ-022 The data-bit index counts 0..DATA_WIDTH-1. The state leaves DATA after the last bit's period expires.
REQ-023 A transfer in the last clock of the final stop bit goes directly to START, with no idle cycle between frames.
REQ-024 With no transfer at the end of the final stop bit, the state goes to IDLE with tx_out=1 and busy=0.
REQ-025 tx_out = 1 in IDLE, STOP1 and STOP2, and 0 in START and BREAK.

Reset
REQ-026 When rst is high at a clock edge: state=IDLE, tx_out=1, busy=0, all counters=0, latched data=0.
REQ-027 Reset mid-frame aborts the frame immediately. No partial bits are emitted after the reset edge.
REQ-028 ready is 0 while rst is high.

Configuration
REQ-029 Macro UART_TX_BREAK_EN.
- Defined: break_req exists. In IDLE, break_req=1 enters BREAK and has priority over data_valid; ready=0 while break_req=1. BREAK holds tx_out=0 for at least one bit_period and continues while break_req=1, checked at each bit boundary. On exit it passes through STOP1 for one bit_period, then goes to IDLE.
- Undefined: no break_req port, no BREAK state, and ready depends only on state.

Structure
REQ-030 Shared package uart_pkg holds the state enumeration, the default DATA_WIDTH and PRESC_W, and the parity-mode constants.
REQ-031 One sub-module, uart_tx_bit_timer, holds the bit-period down-counter. It has a load/enable input and a one-cycle bit_end pulse output.
REQ-032 The FSM, data shift register, bit index counter and parity logic stay in uart_tx_ctrl.

Verification
REQ-033 DATA_WIDTH=8, bit_period=4, parity off, 1 stop, data 0xA5.
- tx_out = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks, 40 clocks total.
- busy falls the clock after the stop bit.
REQ-034 Parity on, even then odd, data 0x07.
- Parity bit = 1 for even and 0 for odd.
- Frame is 11 bits; with stop2_en=1 it is 12 bits.
REQ-035 data_valid held high with words 0x11, 0x22.
- The second start bit immediately follows the first stop bit, with no idle clock.
- ready pulses exactly once per frame, in the last stop clock.
REQ-036 bit_period=0, then bit_period changed to 9 mid-frame.
- Each bit lasts 1 clock.
- The frame in progress is unaffected.
REQ-037 rst asserted during DATA bit 3.
- Next clock: tx_out=1, busy=0, ready=0.
- After release, a new word transmits correctly.
REQ-038 UART_TX_BREAK_EN defined, break_req high for 10 clocks with bit_period=4 and data_valid=1.
- tx_out=0 for 12 clocks, then 1 for 4 clocks.
- The pending word starts after returning to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, defaults and parity constants for the UART transmitter
// Purpose: common definitions imported by uart_tx_ctrl and uart_tx_bit_timer.
// Contents: default DATA_WIDTH / PRESC_W, parity-mode constants, FSM state enum,
//           parity helper function.
// Macro: UART_TX_BREAK_EN adds the BREAK state to the enumeration.
package uart_pkg;

  localparam int UART_DATA_WIDTH_DEF = 8;
  localparam int UART_PRESC_W_DEF    = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } uart_state_t;

  // data_xor is the XOR of all data bits; odd mode inverts it.
  function automatic logic parity_bit(input logic data_xor, input logic mode);
    return data_xor ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - bit-period down-counter for the UART transmitter
// Purpose: times one serial bit; bit_end marks the last clock of the bit.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - reload counter with period-1 (takes priority over counting)
//   en        - counter running (a bit is being sent)
//   period    - clocks per bit, must be >= 1
//   bit_end   - one-cycle pulse in the final clock of the current bit
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESC_W = UART_PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [PRESC_W-1:0] period,
  output logic               bit_end
);

  logic [PRESC_W-1:0] cnt;

  // Counter sits at period-1 on the first clock of a bit and reaches zero on its last.
  assign bit_end = en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period - PRESC_W'(1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller: framing FSM, shift register, parity
// Purpose: serialises parallel words into START/DATA/PARITY/STOP frames.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   data_in/data_valid - word offered; accepted when data_valid && ready
//   ready              - combinational, high in IDLE and the last clock of the final stop bit
//   parity_en/odd      - parity enable / odd select (latched per frame)
//   stop2_en           - two stop bits (latched per frame)
//   bit_period         - clocks per bit, 0 treated as 1 (latched per frame)
//   break_req          - line-break request (only with UART_TX_BREAK_EN)
//   tx_out             - registered serial output, idle high
//   busy               - registered, high outside IDLE
// Macro: UART_TX_BREAK_EN enables break_req and the BREAK state.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH_DEF,
  parameter int PRESC_W    = UART_PRESC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  ready,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2_en,
  input  logic [PRESC_W-1:0]    bit_period,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  tx_out,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      bit_idx;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  stop2_q;
  logic [PRESC_W-1:0]    period_q;
  logic [PRESC_W-1:0]    period_in;
  logic [PRESC_W-1:0]    load_val;
  logic                  bit_end;
  logic                  timer_load;
  logic                  timer_en;
  logic                  frame_end;
  logic                  ready_state;
  logic                  xfer;
  logic                  brk_go;
  logic                  brk_exit;

  assign period_in = (bit_period == '0) ? PRESC_W'(1) : bit_period;

`ifdef UART_TX_BREAK_EN
  // Set while the STOP1 that follows a break is in progress; that stop bit
  // always returns to IDLE and never offers ready.
  logic from_break;
  assign brk_go   = (state == ST_IDLE) && break_req;
  assign brk_exit = from_break;
`else
  assign brk_go   = 1'b0;
  assign brk_exit = 1'b0;
`endif

  // Last clock of the final stop bit of the frame.
  assign frame_end = bit_end &&
                     ((state == ST_STOP2) ||
                      ((state == ST_STOP1) && (!stop2_q || brk_exit)));

  assign ready_state = (state == ST_IDLE) || (frame_end && !brk_exit);

`ifdef UART_TX_BREAK_EN
  assign ready = !rst && !break_req && ready_state;
`else
  assign ready = !rst && ready_state;
`endif

  assign xfer     = ready && data_valid;
  assign timer_en = (state != ST_IDLE);

  // A new frame or break reloads from the live input; bit boundaries inside
  // a frame reload from the latched period.
  always_comb begin
    timer_load = 1'b0;
    load_val   = period_q;
    if (xfer || brk_go) begin
      timer_load = 1'b1;
      load_val   = period_in;
    end else if (bit_end && !frame_end) begin
      timer_load = 1'b1;
    end
  end

  uart_tx_bit_timer #(
    .PRESC_W (PRESC_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .en      (timer_en),
    .period  (load_val),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      data_q    <= '0;
      shift_q   <= '0;
      bit_idx   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      period_q  <= '0;
`ifdef UART_TX_BREAK_EN
      from_break <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (brk_go) begin
            state    <= ST_BREAK;
            tx_out   <= 1'b0;
            busy     <= 1'b1;
            period_q <= period_in;
          end
`endif
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            tx_out  <= shift_q[0];
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en_q) begin
                state  <= ST_PARITY;
                tx_out <= parity_bit(^data_q, par_odd_q);
              end else begin
                state  <= ST_STOP1;
                tx_out <= 1'b1;
              end
            end else begin
              // Bit 0 of shift_q is on the line; bit 1 is next.
              bit_idx <= bit_idx + 1'b1;
              shift_q <= shift_q >> 1;
              tx_out  <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state  <= ST_STOP1;
            tx_out <= 1'b1;
          end
        end
        ST_STOP1: begin
          if (bit_end) begin
            if (stop2_q && !brk_exit) begin
              state  <= ST_STOP2;
              tx_out <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              tx_out <= 1'b1;
              busy   <= 1'b0;
`ifdef UART_TX_BREAK_EN
              from_break <= 1'b0;
`endif
            end
          end
        end
        ST_STOP2: begin
          if (bit_end) begin
            state  <= ST_IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          // break_req is only sampled at bit boundaries so the line stays
          // low for a whole number of bit periods.
          if (bit_end && !break_req) begin
            state      <= ST_STOP1;
            tx_out     <= 1'b1;
            from_break <= 1'b1;
          end
        end
`endif
        default: begin
          state  <= ST_IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase

      // Accepting a word overrides the IDLE/STOP transition above, which is
      // what makes back-to-back frames seamless.
      if (xfer) begin
        state     <= ST_START;
        tx_out    <= 1'b0;
        busy      <= 1'b1;
        data_q    <= data_in;
        shift_q   <= data_in;
        bit_idx   <= '0;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
        stop2_q   <= stop2_en;
        period_q  <= period_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl against a per-clock line model
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2_en;
  logic [7:0] bit_period;
  logic       break_req;
  logic       tx_out;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Expected line level for every upcoming clock, and whether ready may be
  // high in that clock (only the last clock of a frame's final stop bit).
  logic exp_tx[$];
  logic exp_rdy[$];
  int   brk_phase = 0;  // 0 none, 1 line held low, 2 stop after break
  int   brk_p = 1;
  logic last_xfer;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .DATA_WIDTH (8),
    .PRESC_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2_en   (stop2_en),
    .bit_period (bit_period),
`ifdef UART_TX_BREAK_EN
    .break_req  (break_req),
`endif
    .tx_out     (tx_out),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_period(input logic [7:0] bp);
    return (bp == 8'd0) ? 1 : int'(bp);
  endfunction

  task automatic push_level(input logic lvl, input int p);
    for (int k = 0; k < p; k++) begin
      exp_tx.push_back(lvl);
      exp_rdy.push_back(1'b0);
    end
  endtask

  task automatic push_frame(input logic [7:0] w, input logic pe, input logic po,
                            input logic s2, input logic [7:0] bp);
    int p;
    p = eff_period(bp);
    push_level(1'b0, p);
    for (int i = 0; i < 8; i++) push_level(w[i], p);
    if (pe) push_level((^w) ^ po, p);
    push_level(1'b1, p);
    if (s2) push_level(1'b1, p);
    exp_rdy[exp_rdy.size()-1] = 1'b1;
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic tick();
    logic exp_ready;
    logic was_empty;
    #1;
    was_empty = (exp_tx.size() == 0);
    if (rst) exp_ready = 1'b0;
    else if (was_empty) exp_ready = !break_req;
    else exp_ready = exp_rdy[0];
    check_val("ready", {31'd0, ready}, {31'd0, exp_ready});
    last_xfer = exp_ready && data_valid;
    @(posedge clk);
    if (rst) begin
      exp_tx.delete();
      exp_rdy.delete();
      brk_phase = 0;
    end else begin
      if (!was_empty) begin
        void'(exp_tx.pop_front());
        void'(exp_rdy.pop_front());
      end
      if (last_xfer) begin
        push_frame(data_in, parity_en, parity_odd, stop2_en, bit_period);
      end else if (!was_empty && exp_tx.size() == 0 && brk_phase == 1) begin
        if (break_req) begin
          push_level(1'b0, brk_p);
        end else begin
          push_level(1'b1, brk_p);
          brk_phase = 2;
        end
      end else if (!was_empty && exp_tx.size() == 0 && brk_phase == 2) begin
        brk_phase = 0;
      end else if (was_empty && break_req) begin
        brk_p = eff_period(bit_period);
        push_level(1'b0, brk_p);
        brk_phase = 1;
      end
    end
    @(negedge clk);
    check_val("tx_out", {31'd0, tx_out}, (exp_tx.size() != 0) ? {31'd0, exp_tx[0]} : 32'd1);
    check_val("busy", {31'd0, busy}, {31'd0, (exp_tx.size() != 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] w, input logic pe, input logic po,
                      input logic s2, input logic [7:0] bp);
    int guard;
    guard = 0;
    data_in    = w;
    parity_en  = pe;
    parity_odd = po;
    stop2_en   = s2;
    bit_period = bp;
    data_valid = 1'b1;
    last_xfer  = 1'b0;
    while (!last_xfer && guard < 300) begin
      tick();
      guard++;
    end
    if (!last_xfer) check_val("send_timeout", 32'd0, 32'd1);
    data_valid = 1'b0;
  endtask

  int busy_len;
  int brk_hold;

  initial begin
    rst = 1'b1; data_in = '0; data_valid = 1'b0; parity_en = 1'b0;
    parity_odd = 1'b0; stop2_en = 1'b0; bit_period = 8'd4; break_req = 1'b0;
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(3);

    // 0xA5, 8N1, 4 clocks per bit: 40-clock frame
    send(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4);
    busy_len = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy) busy_len++;
      tick();
    end
    check_val("a5_busy_len", busy_len, 32'd40);

    // parity even / odd on 0x07, then with two stop bits
    send(8'h07, 1'b1, 1'b0, 1'b0, 8'd2);
    idle(30);
    send(8'h07, 1'b1, 1'b1, 1'b0, 8'd2);
    idle(30);
    send(8'h07, 1'b1, 1'b1, 1'b1, 8'd3);
    idle(45);

    // back-to-back words with data_valid held
    send(8'h11, 1'b0, 1'b0, 1'b0, 8'd3);
    send(8'h22, 1'b0, 1'b0, 1'b0, 8'd3);
    idle(40);

    // bit_period 0 acts as 1; later period change must not disturb the frame
    send(8'h5A, 1'b1, 1'b0, 1'b1, 8'd0);
    bit_period = 8'd9;
    parity_odd = 1'b1;
    data_in    = 8'hFF;
    idle(15);

    // reset during data bit 3 (start 4 clocks + 3 bits + 2 clocks in)
    send(8'hC3, 1'b0, 1'b0, 1'b0, 8'd4);
    idle(17);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    send(8'h3C, 1'b1, 1'b0, 1'b0, 8'd2);
    idle(30);

`ifdef UART_TX_BREAK_EN
    // 10-clock break with a word pending
    bit_period = 8'd4;
    data_in    = 8'h96;
    data_valid = 1'b1;
    break_req  = 1'b1;
    idle(10);
    break_req  = 1'b0;
    send(8'h96, 1'b0, 1'b0, 1'b0, 8'd4);
    idle(50);
`endif

    // randomized traffic with mid-frame input changes and occasional resets
    brk_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      data_in    = 8'($urandom);
      data_valid = ($urandom_range(0, 3) != 0);
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2_en   = 1'($urandom);
      bit_period = 8'($urandom_range(0, 4));
      rst        = ($urandom_range(0, 399) == 0);
`ifdef UART_TX_BREAK_EN
      if (brk_hold > 0) begin
        break_req = 1'b1;
        brk_hold--;
      end else if ($urandom_range(0, 150) == 0) begin
        break_req = 1'b1;
        brk_hold  = $urandom_range(0, 10);
      end else begin
        break_req = 1'b0;
      end
`endif
      tick();
    end
    rst = 1'b0; data_valid = 1'b0; break_req = 1'b0;
    idle(60);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
